// File: rtl/pipe_execute.sv
// Execute stage: ALU, condition codes and branch/cmov condition; optional PIPE_EXECUTE_STAT_EN adds out_ins_err.
// Latency: one cycle from input transfer to registered out_* / CC.
// Backpressure: stall holds outputs and CC and deasserts in_ready; bubble loads a NOP.
module pipe_execute #(
    parameter int WIDTH = 64,
    parameter int STEP  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valB,
    input  logic [WIDTH-1:0] valC,
    input  logic             stall,
    input  logic             bubble,
    output logic             out_valid,
    output logic [3:0]       out_icode,
    output logic [WIDTH-1:0] out_valE,
    output logic [WIDTH-1:0] out_valA,
    output logic             out_cnd,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of
`ifdef PIPE_EXECUTE_STAT_EN
    ,
    output logic             out_ins_err
`endif
);
    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_of;
    logic             cnd;
    logic             cnd_out;
    logic             load;

    assign in_ready = ~stall;
    assign load     = in_valid & ~bubble;
    assign sum      = valB + valA;
    assign diff     = valB - valA;

    always_comb begin
        alu_res = '0;
        alu_of  = 1'b0;
        case (icode)
            4'h2: alu_res = valA;
            4'h3: alu_res = valC;
            4'h4, 4'h5: alu_res = valB + valC;
            4'h6: begin
                case (ifun)
                    4'h0: begin
                        alu_res = sum;
                        alu_of  = (valA[MSB] == valB[MSB]) && (sum[MSB] != valA[MSB]);
                    end
                    4'h1: begin
                        alu_res = diff;
                        alu_of  = (valA[MSB] != valB[MSB]) && (diff[MSB] != valB[MSB]);
                    end
                    4'h2: alu_res = valB & valA;
                    4'h3: alu_res = valB ^ valA;
                    default: alu_res = '0;
                endcase
            end
            4'h8, 4'hA: alu_res = valB - STEP_W;
            4'h9, 4'hB: alu_res = valB + STEP_W;
            default: alu_res = '0;
        endcase
    end

    // Condition uses the CC register as it stood before this instruction.
    always_comb begin
        cnd = 1'b0;
        case (ifun)
            4'h0: cnd = 1'b1;
            4'h1: cnd = (cc_sf ^ cc_of) | cc_zf;
            4'h2: cnd = cc_sf ^ cc_of;
            4'h3: cnd = cc_zf;
            4'h4: cnd = ~cc_zf;
            4'h5: cnd = ~(cc_sf ^ cc_of);
            4'h6: cnd = ~(cc_sf ^ cc_of) & ~cc_zf;
            default: cnd = 1'b0;
        endcase
        cnd_out = ((icode == 4'h2) || (icode == 4'h7)) ? cnd : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_icode <= 4'h1;
            out_valE  <= '0;
            out_valA  <= '0;
            out_cnd   <= 1'b0;
            cc_zf     <= 1'b1;
            cc_sf     <= 1'b0;
            cc_of     <= 1'b0;
`ifdef PIPE_EXECUTE_STAT_EN
            out_ins_err <= 1'b0;
`endif
        end else if (!stall) begin
            if (load) begin
                out_valid <= 1'b1;
                out_icode <= icode;
                out_valE  <= alu_res;
                out_valA  <= valA;
                out_cnd   <= cnd_out;
                if (icode == 4'h6) begin
                    cc_zf <= (alu_res == '0);
                    cc_sf <= alu_res[MSB];
                    cc_of <= alu_of;
                end
`ifdef PIPE_EXECUTE_STAT_EN
                out_ins_err <= (icode > 4'hB);
`endif
            end else begin
                out_valid <= 1'b0;
                out_icode <= 4'h1;
                out_valE  <= '0;
                out_valA  <= '0;
                out_cnd   <= 1'b0;
`ifdef PIPE_EXECUTE_STAT_EN
                out_ins_err <= 1'b0;
`endif
            end
        end
    end
endmodule
